// File: rtl/lru_pkg.sv
// Shared widths, event codes and state codes for the 2-way LRU replacement table.
package lru_pkg;

    localparam int unsigned LINE_W  = 7;
    localparam int unsigned STATE_W = 2;
    localparam int unsigned DEPTH   = 1 << LINE_W;

    localparam logic [1:0] EV_IDLE = 2'b00;
    localparam logic [1:0] EV_WAY0 = 2'b01;
    localparam logic [1:0] EV_WAY1 = 2'b10;
    localparam logic [1:0] EV_INV  = 2'b11;

    // State is {valid, lru_way}; 2'b01 is unreachable and reads as empty.
    localparam logic [STATE_W-1:0] ST_EMPTY = 2'b00;
    localparam logic [STATE_W-1:0] ST_LRU0  = 2'b10;
    localparam logic [STATE_W-1:0] ST_LRU1  = 2'b11;

endpackage

// File: rtl/lru_next_state.sv
// Combinational LRU next-state function ns(s, v), including 01 -> 00 normalisation.
module lru_next_state
    import lru_pkg::*;
(
    input  logic [STATE_W-1:0] i_state,
    input  logic [1:0]         i_ev,
    output logic [STATE_W-1:0] o_state
);

    logic [STATE_W-1:0] w_norm;

    always_comb begin
        w_norm  = (i_state == 2'b01) ? ST_EMPTY : i_state;
        o_state = w_norm;
        case (i_ev)
            EV_IDLE: o_state = w_norm;
            EV_WAY0: o_state = ST_LRU1;   // way0 just used, way1 becomes LRU
            EV_WAY1: o_state = ST_LRU0;
            EV_INV:  o_state = ST_EMPTY;
            default: o_state = w_norm;
        endcase
    end

endmodule

// File: rtl/lru_pred_table.sv
// Per-set 2-way LRU state table (128 sets) with combinational read and per-edge update.
// Optional same-cycle forwarding of the update onto dout when LRU_FWD_EN is defined.
module lru_pred_table
    import lru_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [LINE_W-1:0]  line,
    input  logic [1:0]         v,
    output logic [STATE_W-1:0] dout,
    output logic               victim
);

    logic [STATE_W-1:0] r_table [0:DEPTH-1];
    logic [STATE_W-1:0] w_cur;
    logic [STATE_W-1:0] w_ns;

    assign w_cur = r_table[line];

    lru_next_state u_ns_wr (
        .i_state (w_cur),
        .i_ev    (v),
        .o_state (w_ns)
    );

    // Reset clears every set in one edge and takes priority over the update.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_table[LINE_W'(i)] <= ST_EMPTY;
            end
        end else begin
            r_table[line] <= w_ns;
        end
    end

`ifdef LRU_FWD_EN
    logic [STATE_W-1:0] w_fwd;

    lru_next_state u_ns_rd (
        .i_state (w_cur),
        .i_ev    (v),
        .o_state (w_fwd)
    );

    assign dout = (v != EV_IDLE) ? w_fwd : w_cur;
`else
    assign dout = w_cur;
`endif

    assign victim = dout[0];

endmodule

// File: tb/tb_lru_pred_table.sv
// Directed bench for lru_pred_table: per-cycle check against a valid/LRU-way model plus literal checks.
module tb_lru_pred_table;

    logic       clk;
    logic       reset;
    logic [6:0] line;
    logic [1:0] v;
    logic [1:0] dout;
    logic       victim;

    int n_checks;
    int n_pass;

    // Model: per set, whether it holds data and which way is least recently used.
    bit  m_valid [128];
    int  m_lru   [128];
    bit  m_ok;

    lru_pred_table dut (
        .clk    (clk),
        .reset  (reset),
        .line   (line),
        .v      (v),
        .dout   (dout),
        .victim (victim)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] view(input bit valid, input int lru);
        if (!valid) return 2'b00;
        return {1'b1, (lru == 1) ? 1'b1 : 1'b0};
    endfunction

    // Expected read of a set after applying event ev, without committing it.
    function automatic logic [1:0] view_after(input int idx, input logic [1:0] ev);
        case (ev)
            2'd1:    return view(1'b1, 1);  // way0 used -> way1 is LRU
            2'd2:    return view(1'b1, 0);
            2'd3:    return view(1'b0, 0);
            default: return view(m_valid[idx], m_lru[idx]);
        endcase
    endfunction

    task automatic check(input string name, input logic [1:0] got, input logic [1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (t=%0t line=%0d v=%b)", name, got, exp, $time, line, v);
    endtask

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 128; i++) begin
                m_valid[i] = 1'b0;
                m_lru[i]   = 0;
            end
            m_ok = 1'b1;
        end else if (m_ok) begin
            case (v)
                2'd1: begin m_valid[line] = 1'b1; m_lru[line] = 1; end
                2'd2: begin m_valid[line] = 1'b1; m_lru[line] = 0; end
                2'd3: begin m_valid[line] = 1'b0; m_lru[line] = 0; end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        logic [1:0] exp;
        if (m_ok) begin
`ifdef LRU_FWD_EN
            exp = view_after(int'(line), v);
`else
            exp = view(m_valid[line], m_lru[line]);
`endif
            check("cycle_dout", dout, exp);
            check("cycle_victim", {1'b0, victim}, {1'b0, exp[0]});
        end
    end

    // Present an event, take one edge, then return to idle.
    task automatic step(input logic [6:0] l, input logic [1:0] ev, input logic rst_n);
        line  = l;
        v     = ev;
        reset = rst_n;
        @(posedge clk);
        #1;
        v     = 2'b00;
        reset = 1'b1;
    endtask

    task automatic peek(input string name, input logic [6:0] l, input logic [1:0] exp);
        line = l;
        #1;
        check(name, dout, exp);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        m_ok     = 1'b0;
        reset    = 1'b0;
        line     = 7'd2;
        v        = 2'b00;

        step(7'd2, 2'b00, 1'b0);
        peek("rst_line0", 7'd0, 2'b00);
        peek("rst_line2", 7'd2, 2'b00);
        peek("rst_line127", 7'd127, 2'b00);
        check("rst_victim", {1'b0, victim}, 2'b00);

        step(7'd2, 2'b01, 1'b1);
        peek("hit0_line2", 7'd2, 2'b11);
        check("hit0_victim", {1'b0, victim}, 2'b01);
        peek("hit0_line3", 7'd3, 2'b00);

        step(7'd2, 2'b00, 1'b1);
        peek("idle_hold", 7'd2, 2'b11);
        step(7'd2, 2'b11, 1'b1);
        peek("inv", 7'd2, 2'b00);
        step(7'd2, 2'b10, 1'b1);
        peek("hit1", 7'd2, 2'b10);
        step(7'd2, 2'b01, 1'b1);
        peek("hit0_again", 7'd2, 2'b11);

        step(7'd5, 2'b10, 1'b1);
        step(7'd6, 2'b01, 1'b1);
        peek("line5", 7'd5, 2'b10);
        peek("line6", 7'd6, 2'b11);
        peek("line2_kept", 7'd2, 2'b11);

        // Back-to-back events chain on one set, and the top index behaves like any other.
        line = 7'd7; v = 2'b01;
        @(posedge clk); #1;
        v = 2'b10;
        @(posedge clk); #1;
        v = 2'b00;
        peek("chain", 7'd7, 2'b10);
        step(7'd127, 2'b10, 1'b1);
        peek("top_line", 7'd127, 2'b10);
        peek("bottom_line", 7'd0, 2'b00);

        step(7'd2, 2'b01, 1'b0);
        peek("rst_drops_update", 7'd2, 2'b00);
        peek("rst_clears5", 7'd5, 2'b00);
        step(7'd5, 2'b10, 1'b1);
        peek("post_rst_event", 7'd5, 2'b10);

        line = 7'd9;
        v    = 2'b01;
        #1;
`ifdef LRU_FWD_EN
        check("fwd_before_edge", dout, 2'b11);
`else
        check("nofwd_before_edge", dout, 2'b00);
`endif
        @(posedge clk); #1;
        v = 2'b00;
        peek("after_edge9", 7'd9, 2'b11);

        @(posedge clk); #1;
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
